// File: rtl/spart_pkg.sv
// ---------------------------------------------------------------------------
// spart_pkg
// Shared constants and types for the SPART receive-side word path.
//   SPART_WORD_W   : width of an assembled word (16)
//   SPART_BYTE_W   : width of a received byte (8)
//   SPART_RX_DEPTH : default number of queued words
//   spart_word_t   : 16-bit word type
//   spart_byte_t   : 8-bit byte type
// ---------------------------------------------------------------------------
package spart_pkg;

  localparam int SPART_WORD_W   = 16;
  localparam int SPART_BYTE_W   = 8;
  localparam int SPART_RX_DEPTH = 4;

  typedef logic [SPART_WORD_W-1:0] spart_word_t;
  typedef logic [SPART_BYTE_W-1:0] spart_byte_t;

endpackage

// File: rtl/spart_word_fifo.sv
// ---------------------------------------------------------------------------
// spart_word_fifo
// First-word-fall-through queue of 16-bit words.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i (accepted when not full, or when a pop
//                  happens in the same cycle)
//   push_data_i  : word to write
//   pop_i        : drop the head word (ignored when empty)
//   head_o       : head word, 0 when empty (combinational, no extra stage)
//   full_o       : DEPTH words queued
//   empty_o      : no words queued
//   count_o      : number of queued words
// Handshake: push_i/pop_i are single-cycle requests sampled on the rising
// edge; a push is accepted when !full_o or a pop is accepted in the same
// cycle; a pop is accepted only when !empty_o.
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module spart_word_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH = SPART_RX_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  spart_word_t              push_data_i,
  input  logic                     pop_i,
  output spart_word_t              head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  spart_word_t       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A pop in the same cycle frees the slot a full-queue push needs.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/spart_rx_assembler.sv
// ---------------------------------------------------------------------------
// spart_rx_assembler
// Assembles received SPART bytes (low byte first) into 16-bit words and
// queues them for the processor's write-back select.
//   clk, rst    : clock, asynchronous active-high reset
//   rx_valid    : one-cycle strobe, rx_data holds a received byte
//   rx_data     : received byte
//   byte_mode   : 1 = each byte becomes {8'h00, byte}
//   rd_en       : pop the head word (ignored when data_valid = 0)
//   clr_ovf     : clear the sticky overflow flag
//   data        : head word, 16'h0000 when empty
//   data_valid  : queue not empty
//   half        : a low byte is pending (this is the assembly state)
//   count       : number of queued words
//   overflow    : sticky, a completed word was dropped on a full queue
// Handshake: rx_valid is a strobe with no back-pressure; a word completed
// while the queue is full and not being popped is dropped and flagged.
// ---------------------------------------------------------------------------
module spart_rx_assembler
  import spart_pkg::*;
#(
  parameter int DEPTH = SPART_RX_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   byte_mode,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [15:0]            data,
  output logic                   data_valid,
  output logic                   half,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  spart_byte_t pend_q, pend_d;
  logic        half_q, half_d;
  logic        ovf_q, ovf_d;

  logic        push;
  spart_word_t push_word;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        drop;

  // Word completion: byte mode always completes; word mode completes on
  // the second byte. Any pending low byte is discarded in byte mode.
  assign push      = rx_valid & (byte_mode | half_q);
  assign push_word = byte_mode ? {8'h00, rx_data} : {rx_data, pend_q};
  assign pop       = rd_en & ~fifo_empty;
  assign drop      = push & fifo_full & ~pop;

  always_comb begin
    half_d = half_q;
    pend_d = pend_q;
    if (rx_valid) begin
      if (byte_mode) begin
        half_d = 1'b0;
      end else if (!half_q) begin
        half_d = 1'b1;
        pend_d = rx_data;
      end else begin
        half_d = 1'b0;
      end
    end
  end

  // A new drop takes priority over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      half_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      half_q <= half_d;
      ovf_q  <= ovf_d;
    end
  end

  spart_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (pop),
    .head_o      (data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count)
  );

  assign data_valid = ~fifo_empty;
  assign half       = half_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_spart_rx_assembler.sv
module tb_spart_rx_assembler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        byte_mode = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] data;
  logic        data_valid;
  logic        half;
  logic [2:0]  count;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of queued words plus assembly state.
  logic [15:0] m_q[$];
  bit          m_half;
  logic [7:0]  m_pend;
  bit          m_ovf;

  spart_rx_assembler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .byte_mode  (byte_mode),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .data       (data),
    .data_valid (data_valid),
    .half       (half),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : 16'h0000;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_half = 0;
    m_pend = '0;
    m_ovf  = 0;
  endtask

  // Drive one cycle, advance the model across the edge, sample #1 later.
  task automatic step(input bit v, input logic [7:0] b, input bit bm,
                      input bit rd, input bit clr);
    bit          dropped;
    bit          do_push;
    logic [15:0] w;
    rx_valid = v; rx_data = b; byte_mode = bm; rd_en = rd; clr_ovf = clr;
    @(posedge clk);
    dropped = 0;
    do_push = 0;
    w = '0;
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (v) begin
      if (bm) begin
        w = {8'h00, b}; do_push = 1; m_half = 0;
      end else if (!m_half) begin
        m_pend = b; m_half = 1;
      end else begin
        w = {b, m_pend}; do_push = 1; m_half = 0;
      end
    end
    if (do_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    #1;
    rx_valid = 0; rd_en = 0; clr_ovf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_reset();
    step(1, 8'h77, 0, 0, 0);       // leave a pending byte
    do_reset();
    n_tests++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_tests++; if (half !== 1'b0) begin n_fail++; $display("FAIL reset_half: got %b want 0", half); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_word_assembly();
    step(1, 8'h34, 0, 0, 0);
    n_tests++; if (half !== 1'b1 || data_valid !== 1'b0) begin n_fail++; $display("FAIL asm_low: half=%b valid=%b want 1,0", half, data_valid); end
    step(1, 8'h12, 0, 0, 0);
    n_tests++; if (data !== 16'h1234) begin n_fail++; $display("FAIL asm_data: got %h want 1234", data); end
    n_tests++; if (data_valid !== 1'b1 || half !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL asm_flags: valid=%b half=%b count=%0d want 1,0,1", data_valid, half, count); end
    step(0, 8'h00, 0, 1, 0);
    n_tests++; if (count !== 3'd0 || data !== 16'h0000) begin n_fail++; $display("FAIL asm_pop: count=%0d data=%h want 0,0000", count, data); end
  endtask

  task automatic test_byte_mode();
    step(1, 8'hA5, 1, 0, 0);
    n_tests++; if (data !== 16'h00A5) begin n_fail++; $display("FAIL bm_data: got %h want 00a5", data); end
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 1, 0, 0);
    n_tests++; if (half !== 1'b0 || count !== 3'd2) begin n_fail++; $display("FAIL bm_discard: half=%b count=%0d want 0,2", half, count); end
    step(0, 8'h00, 0, 1, 0);
    n_tests++; if (data !== 16'h0022) begin n_fail++; $display("FAIL bm_second: got %h want 0022", data); end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      step(1, 8'(i + 1), 0, 0, 0);
      step(1, 8'(8'hA0 + i), 0, 0, 0);
    end
    n_tests++; if (count !== 3'd4 || overflow !== 1'b1 || half !== 1'b0) begin n_fail++; $display("FAIL ovf_state: count=%0d ovf=%b half=%b want 4,1,0", count, overflow, half); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (data !== {8'(8'hA0 + i), 8'(i + 1)}) begin n_fail++; $display("FAIL ovf_word%0d: got %h want %h", i, data, {8'(8'hA0 + i), 8'(i + 1)}); end
      step(0, 8'h00, 0, 1, 0);
    end
    n_tests++; if (overflow !== 1'b1 || data_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky: ovf=%b valid=%b want 1,0", overflow, data_valid); end
    step(0, 8'h00, 0, 0, 1);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    // Fill, then a drop and a clear in the same cycle: the set wins.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
    step(1, 8'hEE, 1, 0, 1);
    n_tests++; if (overflow !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL ovf_set_wins: ovf=%b count=%0d want 1,4", overflow, count); end
    drain();
    step(0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 1, 0, 0);
    step(1, 8'hCD, 0, 0, 0);
    step(1, 8'hAB, 0, 1, 0);       // completes a word while popping
    n_tests++; if (count !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_state: count=%0d ovf=%b want 4,0", count, overflow); end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp_w;
      exp_w = (i < 3) ? {8'h00, 8'(8'h61 + i)} : 16'hABCD;
      n_tests++; if (data !== exp_w) begin n_fail++; $display("FAIL fpp_order%0d: got %h want %h", i, data, exp_w); end
      step(0, 8'h00, 0, 1, 0);
    end
  endtask

  task automatic test_reset_mid_word();
    step(1, 8'h34, 0, 0, 0);
    step(1, 8'h99, 1, 0, 0);
    do_reset();
    step(1, 8'h78, 0, 0, 0);
    step(1, 8'h56, 0, 0, 0);
    n_tests++; if (data !== 16'h5678 || count !== 3'd1) begin n_fail++; $display("FAIL rst_mid: data=%h count=%0d want 5678,1", data, count); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] sent[$];
    logic [15:0] got[$];
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      sent.push_back({8'h00, b});
      step(1, b, 1, (i > 0), 0);
      got.push_back(data);
      n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count%0d: got %0d want 1", i, count); end
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, got[i], sent[i]); end
    end
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    n_tests++; if (count !== 3'd0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_rd: count=%0d valid=%b want 0,0", count, data_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 35,
           $urandom_range(0, 15) == 0);
      n_tests++; if (data !== m_head()) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", i, data, m_head()); end
      n_tests++; if (count !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, m_q.size()); end
      n_tests++; if (data_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b", i, data_valid); end
      n_tests++; if (half !== m_half) begin n_fail++; $display("FAIL rnd_half@%0d: got %b want %b", i, half, m_half); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_word_assembly();
    test_byte_mode();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_word();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
